// File: rtl/multicycle_control_if.sv
// multicycle_control_if: opcode/handshake inputs and datapath control outputs of the multi-cycle RV32I controller
interface multicycle_control_if;
  logic [6:0]  opcode;
  logic        mem_ready;
  logic        branch_taken;
  logic [2:0]  state;
  logic        mem_read;
  logic        mem_write;
  logic        i_or_d;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        alu_src;
  logic [1:0]  alu_op;
  logic        reg_write;
  logic [1:0]  wb_sel;
  logic        instr_done;
  logic        illegal;
  logic [31:0] instret;
  modport master (
    input  opcode, mem_ready, branch_taken,
    output state, mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src,
           alu_src, alu_op, reg_write, wb_sel, instr_done, illegal, instret
  );
  modport slave (
    output opcode, mem_ready, branch_taken,
    input  state, mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src,
           alu_src, alu_op, reg_write, wb_sel, instr_done, illegal, instret
  );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer with retire counter; CTRL_MEM_WAIT_EN enables mem_ready wait states
module multicycle_control (
  input logic                  clk,
  input logic                  reset,
  multicycle_control_if.master bus
);
  localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, TRAP = 3'd7;
  logic [2:0]  state_q, state_d;
  logic [31:0] instret_q, instret_d;
  logic        illegal_q, illegal_d;
  logic        rdy, is_r, is_i, is_ld, is_st, is_br, is_jalr, is_jal, legal;
  assign is_r    = bus.opcode == 7'b0110011;
  assign is_i    = bus.opcode == 7'b0010011;
  assign is_ld   = bus.opcode == 7'b0000011;
  assign is_st   = bus.opcode == 7'b0100011;
  assign is_br   = bus.opcode == 7'b1100011;
  assign is_jalr = bus.opcode == 7'b1100111;
  assign is_jal  = bus.opcode == 7'b1101111;
  assign legal   = is_r | is_i | is_ld | is_st | is_br | is_jalr | is_jal;
`ifdef CTRL_MEM_WAIT_EN
  assign rdy = bus.mem_ready;
`else
  assign rdy = bus.mem_ready | 1'b1;
`endif
  assign bus.state   = state_q;
  assign bus.instret = instret_q;
  assign bus.illegal = illegal_q;
  assign instret_d   = instret_q + {31'b0, bus.instr_done};
  assign illegal_d   = illegal_q | (state_q == DECODE && !legal);
  // state, retire counter and sticky illegal flag
  always_ff @(posedge clk) begin
    state_q   <= reset ? FETCH : state_d;
    instret_q <= reset ? '0 : instret_d;
    illegal_q <= reset ? 1'b0 : illegal_d;
  end
  // next-state sequencing, memory states held until the access completes
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   state_d = rdy ? DECODE : FETCH;
      DECODE:  state_d = legal ? EXEC : TRAP;
      EXEC:    state_d = (is_r | is_i) ? WB : (is_ld | is_st) ? MEM : FETCH;
      MEM:     state_d = !rdy ? MEM : is_ld ? WB : FETCH;
      WB:      state_d = FETCH;
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end
  // datapath strobes per state; everything held low while reset is asserted
  always_comb begin
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_src     = 2'd0;
    bus.alu_src    = 1'b0;
    bus.alu_op     = 2'b00;
    bus.reg_write  = 1'b0;
    bus.wb_sel     = 2'd0;
    bus.instr_done = 1'b0;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          bus.mem_read = 1'b1;
          bus.ir_write = rdy;
        end
        EXEC: begin
          bus.alu_src    = is_i | is_ld | is_st | is_jalr;
          bus.alu_op     = is_r ? 2'b10 : is_i ? 2'b11 : is_br ? 2'b01 : 2'b00;
          bus.reg_write  = is_jal | is_jalr;
          bus.wb_sel     = (is_jal | is_jalr) ? 2'd2 : 2'd0;
          bus.pc_write   = is_br | is_jal | is_jalr;
          bus.pc_src     = is_jalr ? 2'd2 : (is_jal | (is_br & bus.branch_taken)) ? 2'd1 : 2'd0;
          bus.instr_done = is_br | is_jal | is_jalr;
        end
        MEM: begin
          bus.i_or_d     = 1'b1;
          bus.alu_src    = 1'b1;
          bus.mem_read   = !is_st;
          bus.mem_write  = is_st;
          bus.pc_write   = is_st & rdy;
          bus.instr_done = is_st & rdy;
        end
        WB: begin
          bus.reg_write  = 1'b1;
          bus.wb_sel     = is_ld ? 2'd1 : 2'd0;
          bus.pc_write   = 1'b1;
          bus.instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table, directed and random checks of the multi-cycle controller against a per-instruction model
module tb_multicycle_control;
`ifdef CTRL_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011, OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011, OP_JALR = 7'b1100111, OP_JAL = 7'b1101111;
  typedef struct {
    logic [2:0] st; logic mr, mw, iod, irw, pcw; logic [1:0] pcs; logic as; logic [1:0] aop;
    logic rw; logic [1:0] wbs; logic done, ill; logic [31:0] ir;
  } snap_t;
  typedef struct { logic [6:0] op; int fw, mw; logic bt; int cpi_wait, cpi_nowait; logic [6:0] ret; } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  multicycle_control_if b ();
  multicycle_control dut (.clk(clk), .reset(reset), .bus(b));
  always #5 clk = ~clk;
  snap_t tr[$];
  vec_t vt[8];
  logic [6:0] ops[7];
  logic [6:0] next_op;
  int errs = 0, checks = 0, exp_instret = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  // one clock: drive mem_ready, sample at negedge, load the new opcode on the ir_write edge
  task automatic cyc(input logic rdy);
    snap_t s;
    logic irw;
    b.mem_ready = rdy;
    @(negedge clk);
    s.st = b.state; s.mr = b.mem_read; s.mw = b.mem_write; s.iod = b.i_or_d; s.irw = b.ir_write;
    s.pcw = b.pc_write; s.pcs = b.pc_src; s.as = b.alu_src; s.aop = b.alu_op; s.rw = b.reg_write;
    s.wbs = b.wb_sel; s.done = b.instr_done; s.ill = b.illegal; s.ir = b.instret;
    tr.push_back(s);
    irw = b.ir_write;
    @(posedge clk);
    #1;
    if (irw) b.opcode = next_op;
  endtask
  function automatic int exp_cpi(input logic [6:0] op, input int fw, input int mw);
    bit mem = (op == OP_LD) || (op == OP_ST);
    int base = (op == OP_BR || op == OP_JAL || op == OP_JALR) ? 3 : (op == OP_LD) ? 5 : 4;
    return base + (WAIT_EN ? fw + (mem ? mw : 0) : 0);
  endfunction
  function automatic logic [6:0] exp_ret(input logic [6:0] op, input logic bt);
    logic rw = (op == OP_R) || (op == OP_I) || (op == OP_LD) || (op == OP_JAL) || (op == OP_JALR);
    logic [1:0] wbs = (op == OP_LD) ? 2'd1 : (op == OP_JAL || op == OP_JALR) ? 2'd2 : 2'd0;
    logic [1:0] pcs = (op == OP_JALR) ? 2'd2 : (op == OP_JAL || (op == OP_BR && bt)) ? 2'd1 : 2'd0;
    return {rw, wbs, 1'b1, pcs, op == OP_ST};
  endfunction
  // run one instruction with fw fetch waits and mw data waits, checking length and retire strobes
  task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input logic bt,
                           input int cpi, input logic [6:0] ret, input string tag);
    int wcnt = 0, n = 0, lim;
    logic strobe, rdy;
    snap_t l;
    next_op = op;
    tr.delete();
    b.branch_taken = bt;
    do begin
      strobe = b.mem_read | b.mem_write;
      lim = b.i_or_d ? mw : fw;
      rdy = strobe && (wcnt >= lim);
      cyc(rdy);
      wcnt = rdy ? 0 : (strobe ? wcnt + 1 : wcnt);
      n++;
    end while (!tr[tr.size()-1].done && n < 60);
    l = tr[tr.size()-1];
    exp_instret++;
    check($sformatf("%s done", tag), {31'b0, l.done}, 1);
    check($sformatf("%s cycles", tag), tr.size(), cpi);
    check($sformatf("%s retire", tag), {l.rw, l.wbs, l.pcw, l.pcs, l.mw}, ret);
    check($sformatf("%s instret", tag), b.instret, exp_instret);
    check($sformatf("%s next state", tag), b.state, 0);
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    logic mr_any;
    ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JALR, OP_JAL};
    vt[0] = '{OP_R,    0, 0, 1'b0, 4, 4, 7'b1001000};
    vt[1] = '{OP_I,    1, 0, 1'b0, 5, 4, 7'b1001000};
    vt[2] = '{OP_LD,   0, 2, 1'b0, 7, 5, 7'b1011000};
    vt[3] = '{OP_ST,   2, 1, 1'b0, 7, 4, 7'b0001001};
    vt[4] = '{OP_BR,   0, 0, 1'b1, 3, 3, 7'b0001010};
    vt[5] = '{OP_BR,   1, 0, 1'b0, 4, 3, 7'b0001000};
    vt[6] = '{OP_JAL,  0, 0, 1'b0, 3, 3, 7'b1101010};
    vt[7] = '{OP_JALR, 0, 0, 1'b0, 3, 3, 7'b1101100};
    b.opcode = OP_R;
    b.mem_ready = 1'b1;
    b.branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset mem_read", {31'b0, b.mem_read}, 0);
    check("reset ir_write", {31'b0, b.ir_write}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset state", b.state, 0);
    check("reset instret", b.instret, 0);
    check("reset illegal", {31'b0, b.illegal}, 0);
    next_op = OP_ST;
    n = 0;
    while (b.state != 3'd3 && n < 20) begin
      cyc(b.mem_read | b.mem_write);
      n++;
    end
    check("midstore reach MEM", b.state, 3);
    reset = 1'b1;
    b.mem_ready = 1'b1;
    @(negedge clk);
    check("midstore mem_write", {31'b0, b.mem_write}, 0);
    check("midstore pc_write", {31'b0, b.pc_write}, 0);
    check("midstore instr_done", {31'b0, b.instr_done}, 0);
    check("midstore mem_read", {31'b0, b.mem_read}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midstore state", b.state, 0);
    check("midstore instret", b.instret, 0);
    exp_instret = 0;
    for (int i = 0; i < 8; i++)
      run_instr(vt[i].op, vt[i].fw, vt[i].mw, vt[i].bt, WAIT_EN ? vt[i].cpi_wait : vt[i].cpi_nowait,
                vt[i].ret, $sformatf("vec%0d", i));
    run_instr(OP_R, 0, 0, 1'b0, 4, 7'b1001000, "rtype");
    check("rtype s0", tr[0].st, 0);
    check("rtype s1", tr[1].st, 1);
    check("rtype s2", tr[2].st, 2);
    check("rtype s3", tr[3].st, 4);
    check("rtype alu_op", tr[2].aop, 2);
    run_instr(OP_LD, 0, 2, 1'b0, WAIT_EN ? 7 : 5, 7'b1011000, "ldwait");
    n = WAIT_EN ? 3 : 1;
    for (int k = 3; k < 3 + n; k++) begin
      check($sformatf("ldwait mem state c%0d", k), tr[k].st, 3);
      check($sformatf("ldwait mem_read c%0d", k), {31'b0, tr[k].mr}, 1);
      check($sformatf("ldwait i_or_d c%0d", k), {31'b0, tr[k].iod}, 1);
    end
    check("ldwait wb state", tr[3+n].st, 4);
    check("ldwait wb_sel", tr[3+n].wbs, 1);
    run_instr(OP_JALR, 0, 0, 1'b0, 3, 7'b1101100, "jalr");
    check("jalr alu_src", {31'b0, tr[2].as}, 1);
    check("jalr exec state", tr[2].st, 2);
    for (int r = 0; r < 40; r++) begin
      logic [6:0] op;
      int fw, mw;
      logic bt;
      op = ops[$urandom_range(0, 6)];
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      bt = 1'($urandom_range(0, 1));
      run_instr(op, fw, mw, bt, exp_cpi(op, fw, mw), exp_ret(op, bt), $sformatf("rand%0d op%07b", r, op));
    end
    next_op = 7'b0000000;
    tr.delete();
    for (int k = 0; k < 13; k++) cyc(1'b1);
    check("illegal s1", tr[1].st, 1);
    check("illegal trap state", tr[2].st, 7);
    check("illegal flag", {31'b0, tr[2].ill}, 1);
    mr_any = 1'b0;
    for (int k = 3; k < 13; k++) mr_any |= tr[k].mr | tr[k].mw | tr[k].pcw | tr[k].rw;
    check("illegal strobes", {31'b0, mr_any}, 0);
    check("illegal sticky", {31'b0, tr[12].ill}, 1);
    check("illegal instret", b.instret, exp_instret);
    reset = 1'b1;
    cyc(1'b1);
    reset = 1'b0;
    check("trap reset state", b.state, 0);
    check("trap reset illegal", {31'b0, b.illegal}, 0);
    check("trap reset instret", b.instret, 0);
    exp_instret = 0;
    run_instr(OP_I, 0, 0, 1'b0, 4, 7'b1001000, "after trap");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Sequencing controller for the multi-cycle RV32I datapath. A Moore/Mealy FSM steps each instruction through FETCH, DECODE, EXEC, MEM and WB states and drives the datapath enables for each state. Memory accesses take a variable number of cycles, so the FSM waits on a memory-ready handshake. The block sits between the instruction register's opcode field and the shared PC/IR/ALU/memory/register-file datapath, and it also keeps a retired-instruction counter.

## Interface
- No parameters.
- clk  in  1  single clock, all state updates on its rising edge
- reset  in  1  synchronous, active-high
- opcode  in  7  instruction[6:0] from IR; valid from DECODE onward
- mem_ready  in  1  memory accepted/completed current access this cycle
- branch_taken  in  1  ALU compare result, sampled in EXEC for branches
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7
- mem_read / mem_write  out  1  memory request strobes
- i_or_d  out  1  memory address: 0 = PC, 1 = ALU result
- ir_write  out  1  load IR with fetched word
- pc_write  out  1  update PC this cycle
- pc_src  out  2  0 = PC+4, 1 = PC+imm (branch/JAL), 2 = ALU result (JALR)
- alu_src  out  1  0 = rs2, 1 = immediate
- alu_op  out  2  00 add, 01 branch compare, 10 R-type funct, 11 I-type funct
- reg_write  out  1  register file write enable
- wb_sel  out  2  0 = ALU, 1 = memory data, 2 = PC+4
- instr_done  out  1  one-cycle pulse when an instruction retires
- illegal  out  1  sticky, set on unknown opcode
- instret  out  32  retired-instruction count

## Operation
- **Output defaults.** Every output not listed for a state is 0.
- **FETCH:** mem_read=1, i_or_d=0.
  - If mem_ready=1: ir_write=1, next state DECODE.
  - Otherwise stay in FETCH.
- **DECODE:** one cycle, no strobes. Next state by opcode:
  - 0110011, 0010011, 0000011, 0100011, 1100011, 1100111, 1101111 → EXEC.
  - Any other opcode → TRAP.
- **EXEC:** alu_src and alu_op are set per opcode:
  - R-type: alu_src=0, alu_op=10.
  - I-ALU: alu_src=1, alu_op=11.
  - Load/store: alu_src=1, alu_op=00.
  - Branch: alu_src=0, alu_op=01.
- **EXEC next state:**
  - R-type or I-ALU → WB.
  - Load or store → MEM.
  - Branch: pc_write=1, pc_src = branch_taken ? 1 : 0, instr_done=1, next FETCH.
  - JAL: reg_write=1, wb_sel=2, pc_write=1, pc_src=1, instr_done=1, next FETCH.
  - JALR: alu_src=1, alu_op=00, reg_write=1, wb_sel=2, pc_write=1, pc_src=2, instr_done=1, next FETCH.
- **MEM:** i_or_d=1, alu_src=1, alu_op=00, and mem_read=1 (load) or mem_write=1 (store).
  - Store with mem_ready=1: pc_write=1, pc_src=0, instr_done=1, next FETCH.
  - Load with mem_ready=1: next WB.
  - mem_ready=0: stay in MEM with strobes held.
- **WB:** reg_write=1, wb_sel = load ? 1 : 0, pc_write=1, pc_src=0, instr_done=1, next FETCH.
- **TRAP:** illegal=1, all strobes 0. The FSM stays in TRAP until reset.
- **instret:** increments by 1 on each instr_done cycle and wraps from 0xFFFFFFFF to 0.

## Timing
- Reset is sampled on the clock edge. The next state is FETCH, instret=0 and illegal=0.
- While reset=1, all combinational outputs are forced to 0, including the mem_read that FETCH would otherwise drive.
- Reset mid-instruction abandons the instruction. No write strobe (reg_write, mem_write, pc_write, ir_write) is asserted in the reset cycle.
- pc_write, pc_src, ir_write, mem_* and instr_done are Mealy outputs, valid in the same cycle as mem_ready or branch_taken.
- instret and illegal are registered: both update on the edge ending the qualifying cycle.
- CPI with mem_ready tied to 1:
  - Branch, JAL, JALR: 3 cycles.
  - R-type, I-ALU, store: 4 cycles.
  - Load: 5 cycles.
- Each mem_ready=0 cycle in FETCH or MEM adds one cycle.
- The opcode may change only on an ir_write edge. The controller does not re-sample the IR mid-instruction.

## Configuration
- CTRL_MEM_WAIT_EN defined: the FETCH and MEM exits are gated by mem_ready, as described above.
- CTRL_MEM_WAIT_EN undefined: mem_ready is ignored and treated as 1. FETCH and MEM always last exactly one cycle, for use with single-cycle memory.

## Test plan
- **R-type, mem_ready=1.** Reset, then opcode=0110011.
  - States must run 0,1,2,4. In EXEC, alu_op=10.
  - In the 4th cycle: reg_write=1, wb_sel=0, pc_src=0, instr_done=1.
  - Afterwards instret=1.
- **Load with wait (CTRL_MEM_WAIT_EN).** Opcode=0000011, mem_ready=0 for the first 2 MEM cycles.
  - MEM lasts 3 cycles with mem_read=1 and i_or_d=1 throughout.
  - WB follows with wb_sel=1.
  - Total 7 cycles.
- **Branch.** Opcode=1100011.
  - branch_taken=1: pc_write=1, pc_src=1 in cycle 3.
  - Repeat with branch_taken=0: pc_src=0.
  - Both cases: instret +1, no reg_write.
- **JALR.** Opcode=1100111. In EXEC: reg_write=1, wb_sel=2, pc_src=2, alu_src=1. Then FETCH.
- **Illegal opcode.** Opcode=0000000.
  - DECODE → TRAP, illegal=1, mem_read stays 0 for 10 cycles, instret unchanged.
  - Reset clears illegal and returns to FETCH.
- **Reset mid-store.** Store with reset=1 during MEM.
  - That cycle: mem_write=0, pc_write=0, instr_done=0.
  - Next cycle: state=0, instret unchanged.
